// File: rtl/sb_poly_mul_param.sv
// Schoolbook multiplier: acc += a(x)*s(x) mod (x^N+1), coefficients mod 2^QW.
// Defining SB_MUL_CYCLIC_EN adds a mode input selecting cyclic reduction mod (x^N-1).
module sb_poly_mul_param #(
    parameter int N  = 256,
    parameter int QW = 13,
    parameter int SW = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          keep_secret,
    input  logic          acc_clear,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    input  logic [SW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [QW-1:0] a_data,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [IW-1:0] rd_idx,
    output logic [QW-1:0] rd_data
);

    localparam logic [IW:0] LAST = (IW+1)'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD_S, COMPUTE, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW:0]   cnt;
    logic          secret_valid;
    logic          neg_flag;
    logic [SW-1:0] sreg    [N];
    logic [QW-1:0] acc     [N];
    logic [QW-1:0] acc_nxt [N];
    logic          start_accept;
    logic          load_fire;
    logic          comp_fire;
    logic          wrap_flip;

`ifdef SB_MUL_CYCLIC_EN
    logic cyclic_q;

    always_ff @(posedge clk) begin
        if (rst)
            cyclic_q <= 1'b0;
        else if (start_accept)
            cyclic_q <= mode;
    end

    assign wrap_flip = ~cyclic_q;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign wrap_flip   = 1'b1;
`endif

    assign start_accept = start && ((state == IDLE) || (state == DONE));
    assign load_fire    = s_valid && s_ready;
    assign comp_fire    = a_valid && a_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        s_ready   = 1'b0;
        a_ready   = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start)
                    state_nxt = (keep_secret && secret_valid) ? COMPUTE : LOAD_S;
            end
            LOAD_S: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid && (cnt == LAST))
                    state_nxt = COMPUTE;
            end
            COMPUTE: begin
                busy    = 1'b1;
                a_ready = 1'b1;
                if (a_valid && (cnt == LAST))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Effective sign is the stored sign XOR neg_flag; a zero magnitude adds nothing either way.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (sreg[i][SW-1] ^ neg_flag)
                acc_nxt[i] = acc[i] - a_data * QW'(sreg[i][SW-2:0]);
            else
                acc_nxt[i] = acc[i] + a_data * QW'(sreg[i][SW-2:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            secret_valid <= 1'b0;
            neg_flag     <= 1'b0;
            rd_data      <= '0;
            for (int i = 0; i < N; i++) begin
                acc[i]  <= '0;
                sreg[i] <= '0;
            end
        end else begin
            rd_data <= acc[rd_idx];
            if (start_accept && acc_clear) begin
                for (int i = 0; i < N; i++)
                    acc[i] <= '0;
            end
            if (load_fire) begin
                sreg[cnt[IW-1:0]] <= s_data;
                if (cnt == LAST) begin
                    cnt          <= '0;
                    secret_valid <= 1'b1;
                    neg_flag     <= 1'b0;
                end else begin
                    cnt <= cnt + (IW+1)'(1);
                end
            end
            // After N rotations every coefficient has wrapped once; neg_flag undoes those flips.
            if (comp_fire) begin
                for (int i = 0; i < N; i++)
                    acc[i] <= acc_nxt[i];
                for (int i = 1; i < N; i++)
                    sreg[i] <= sreg[i-1];
                sreg[0] <= {sreg[N-1][SW-1] ^ wrap_flip, sreg[N-1][SW-2:0]};
                if (cnt == LAST) begin
                    cnt      <= '0;
                    neg_flag <= neg_flag ^ wrap_flip;
                end else begin
                    cnt <= cnt + (IW+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_poly_mul_param.sv
// Randomized self-checking bench for sb_poly_mul_param (N=4, QW=13, SW=4) against a
// direct polynomial-product model; honours SB_MUL_CYCLIC_EN when defined.
module tb_sb_poly_mul_param;

    localparam int N  = 4;
    localparam int QW = 13;
    localparam int SW = 4;
`ifdef SB_MUL_CYCLIC_EN
    localparam bit CYC_BUILD = 1'b1;
`else
    localparam bit CYC_BUILD = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          keep_secret;
    logic          acc_clear;
    logic          mode;
    logic          busy;
    logic          done;
    logic [SW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [QW-1:0] a_data;
    logic          a_valid;
    logic          a_ready;
    logic [1:0]    rd_idx;
    logic [QW-1:0] rd_data;

    int            checks = 0;
    int            errors = 0;
    logic [SW-1:0] s_vec [N];
    logic [QW-1:0] a_vec [N];
    int            model_acc [N];
    int            model_sv  [N];
    bit            model_sv_valid;

    sb_poly_mul_param #(.N(N), .QW(QW), .SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .keep_secret(keep_secret),
        .acc_clear  (acc_clear),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .a_data     (a_data),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int s_val(input logic [SW-1:0] c);
        return c[SW-1] ? -int'(c[SW-2:0]) : int'(c[SW-2:0]);
    endfunction

    // acc[i] += sum_j a[j]*s[i-j], wrapping terms negated unless the product is cyclic.
    function automatic void model_product(input bit cyc);
        int k;
        int sg;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                k  = i - j;
                sg = 1;
                if (k < 0) begin
                    k += N;
                    if (!cyc) sg = -1;
                end
                model_acc[i] = (model_acc[i] + sg * int'(a_vec[j]) * model_sv[k]) & 32'h1FFF;
            end
        end
    endfunction

    task automatic readAcc(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_idx = 2'(i);
            @(posedge clk); #1;
            checkOutput($sformatf("%s_acc%0d", tag, i), 32'(rd_data), 32'(model_acc[i]));
        end
    endtask

    task automatic applyStimulus(input string tag, input bit keep, input bit clear, input bit md,
                                 input bit gaps, input bit busy_start, input int abort_after);
        bit loading;
        bit fire;
        int idx;
        int cyc;
        loading     = !(keep && model_sv_valid);
        keep_secret = keep;
        acc_clear   = clear;
        mode        = md;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; keep_secret = 1'b0; acc_clear = 1'b0; mode = 1'b0;
        checkOutput({tag, "_busy_start"}, 32'(busy), 32'd1);
        checkOutput({tag, "_done_start"}, 32'(done), 32'd0);
        checkOutput({tag, "_s_ready_start"}, 32'(s_ready), 32'(loading));
        checkOutput({tag, "_a_ready_start"}, 32'(a_ready), 32'(!loading));
        if (clear)
            for (int i = 0; i < N; i++) model_acc[i] = 0;
        if (loading) begin
            idx = 0; cyc = 0;
            while (idx < N && cyc < 200) begin
                s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                s_data  = s_vec[idx];
                fire    = s_valid && s_ready;
                @(posedge clk); #1;
                cyc++;
                if (fire) idx++;
            end
            s_valid = 1'b0;
            if (idx < N) checkOutput({tag, "_s_timeout"}, 32'(idx), 32'(N));
            for (int k = 0; k < N; k++) model_sv[k] = s_val(s_vec[k]);
            model_sv_valid = 1'b1;
        end
        idx = 0; cyc = 0;
        while (idx < N && cyc < 200) begin
            if (abort_after >= 0 && idx == abort_after) break;
            a_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            a_data  = a_vec[idx];
            start   = busy_start && (cyc == 0);
            fire    = a_valid && a_ready;
            @(posedge clk); #1;
            cyc++;
            if (fire) idx++;
        end
        a_valid = 1'b0;
        start   = 1'b0;
        if (abort_after >= 0 && idx == abort_after) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            for (int i = 0; i < N; i++) model_acc[i] = 0;
            model_sv_valid = 1'b0;
            checkOutput({tag, "_busy_rst"}, 32'(busy), 32'd0);
            checkOutput({tag, "_done_rst"}, 32'(done), 32'd0);
            checkOutput({tag, "_a_ready_rst"}, 32'(a_ready), 32'd0);
        end else if (idx < N) begin
            checkOutput({tag, "_a_timeout"}, 32'(idx), 32'(N));
        end else begin
            checkOutput({tag, "_done_end"}, 32'(done), 32'd1);
            checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
            checkOutput({tag, "_a_ready_end"}, 32'(a_ready), 32'd0);
            model_product(CYC_BUILD && md);
        end
        readAcc(tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; keep_secret = 1'b0; acc_clear = 1'b0; mode = 1'b0;
        s_data = '0; s_valid = 1'b0; a_data = '0; a_valid = 1'b0; rd_idx = '0;
        model_sv_valid = 1'b0;
        for (int i = 0; i < N; i++) model_acc[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_s_ready", 32'(s_ready), 32'd0);
        checkOutput("reset_a_ready", 32'(a_ready), 32'd0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
        readAcc("reset");

        s_vec = '{4'd1, 4'd0, 4'd0, 4'd0};
        a_vec = '{13'd5, 13'd6, 13'd7, 13'd8};
        applyStimulus("identity", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);

        s_vec = '{4'd0, 4'd1, 4'd0, 4'd0};
        a_vec = '{13'd1, 13'd2, 13'd3, 13'd4};
        applyStimulus("wrap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        checkOutput("wrap_acc0_const", 32'(model_acc[0]), 32'd8188);
        applyStimulus("reuse", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        s_vec = '{4'b1011, 4'd0, 4'd0, 4'd0};
        a_vec = '{13'd1, 13'd0, 13'd0, 13'd0};
        applyStimulus("negative", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        s_vec = '{4'b1000, 4'd0, 4'd0, 4'd0};
        a_vec = '{13'd4321, 13'd17, 13'd99, 13'd8191};
        applyStimulus("neg_zero", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);

        s_vec = '{4'd0, 4'd1, 4'd0, 4'd0};
        a_vec = '{13'd1, 13'd2, 13'd3, 13'd4};
        applyStimulus("stall", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, -1);

        s_vec = '{4'b0111, 4'b1101, 4'd3, 4'b1001};
        a_vec = '{13'd8000, 13'd123, 13'd4095, 13'd77};
        applyStimulus("abort", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        applyStimulus("after_rst", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);

        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < N; k++) begin
                s_vec[k] = SW'($urandom_range(0, 15));
                a_vec[k] = QW'($urandom_range(0, 8191));
            end
            applyStimulus($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sb_poly_mul_param.md
Name: sb_poly_mul_param

Overview:
Parametrised schoolbook polynomial multiplier for lattice-crypto arithmetic. It computes acc += a(x)·s(x) in Z_{2^QW}[x]/(x^N+1), or optionally in Z_{2^QW}[x]/(x^N−1).
- s is a small signed secret polynomial; a is a public polynomial.
- Both are streamed in with valid/ready handshakes, one coefficient per cycle.
- The accumulator is N coefficients wide; it is read back through an indexed, registered port.
- Sits between the coefficient BRAM readers and the rounding/packing stage. Supports secret reuse and multi-product accumulation for matrix-vector products.

Parameters:
- N, 256, polynomial degree; power of two, ≥4. Localparam IW = $clog2(N).
- QW, 13, coefficient width of a and acc; arithmetic is mod 2^QW.
- SW, 4, secret coefficient width; sign-magnitude, MSB = sign.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle command pulse
- keep_secret  in  1  sampled at start; 1 = reuse the stored secret, skip LOAD_S
- acc_clear  in  1  sampled at start; 1 = zero acc before the product
- mode  in  1  sampled at start; 0 = negacyclic, 1 = cyclic (only with SB_MUL_CYCLIC_EN)
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  high from completion until the next accepted start
- s_data  in  SW  secret coefficient, s[0] first
- s_valid  in  1  secret handshake valid
- s_ready  out  1  high only in LOAD_S
- a_data  in  QW  public coefficient, a[0] first
- a_valid  in  1  public handshake valid
- a_ready  out  1  high only in COMPUTE
- rd_idx  in  IW  accumulator read index
- rd_data  out  QW  acc[rd_idx], registered, 1-cycle latency

Behaviour:
- Reset values: busy=0, done=0, s_ready=0, a_ready=0, rd_data=0, acc all 0, secret register all 0, secret_valid=0, neg_flag=0. State = IDLE.
- States: IDLE, LOAD_S, COMPUTE, DONE.
- Start acceptance: start is accepted only in IDLE or DONE; start while busy is ignored. On the accepting edge:
  - done←0 and busy←1.
  - mode is latched.
  - If acc_clear=1, acc←0.
  - Next state is COMPUTE if keep_secret=1 and secret_valid=1; otherwise LOAD_S.
  - keep_secret=1 with secret_valid=0 forces LOAD_S.
- LOAD_S:
  - Each s_valid&s_ready edge writes the coefficient into slot cnt and increments cnt (IW+1 bits).
  - After the Nth accept: cnt←0, secret_valid←1, neg_flag←0, next state COMPUTE.
  - Stalls on s_valid=0 indefinitely.
- COMPUTE: each a_valid&a_ready edge (step j) does, for all i in parallel:
  - acc[i] ← acc[i] + a_j·sreg[i] mod 2^QW, where the product is negated if sign(sreg[i]) XOR neg_flag.
  - In the same edge, rotate: sreg[i]←sreg[i−1]; sreg[0]←sreg[N−1], with its sign bit inverted in negacyclic mode only.
  - Throughput is one coefficient per cycle, with no bubble between consecutive accepts.
- Pass end: after the Nth accept:
  - In negacyclic mode every coefficient has been sign-flipped once, so neg_flag toggles; in cyclic mode it is unchanged.
  - The net effect is that a reused secret equals the originally loaded s.
  - Next state DONE: busy←0, done←1; a_ready drops the same edge.
- Arithmetic:
  - Magnitude = s[SW−2:0].
  - Negative zero (sign=1, magnitude=0) contributes 0.
  - Product width is QW+SW−1, truncated to QW bits.
- rd_data ← acc[rd_idx] every cycle, in any state. Reads during COMPUTE return partial sums.
- rst mid-operation returns everything to its reset values. secret_valid=0, so the next start always reloads the secret.

Optional Feature:
SB_MUL_CYCLIC_EN:
- Defined: the mode input selects cyclic (x^N−1, no sign flip on wrap, neg_flag never toggles) or negacyclic reduction.
- Undefined: mode is ignored and the block is negacyclic-only; no mode register or mux logic.

Test Plan:
All scenarios use N=4, QW=13, SW=4.
1. Identity: s=[1,0,0,0], a=[5,6,7,8], acc_clear=1 → rd_data over idx 0..3 = [5,6,7,8]; done asserted 1 cycle after the 4th a accept.
2. Negacyclic wrap: s=[0,1,0,0], a=[1,2,3,4] → acc=[8188,1,2,3]. With SB_MUL_CYCLIC_EN and mode=1 → [4,1,2,3].
3. Negative secret: s=[4'b1011,0,0,0], a=[1,0,0,0] → acc=[8189,0,0,0]; s=[4'b1000,…] (negative zero) → all 0.
4. Secret reuse plus accumulate:
   - Run scenario 2.
   - Then start with keep_secret=1, acc_clear=0, same a: LOAD_S is skipped (s_ready stays 0).
   - Result acc=[8184,2,4,6].
5. Handshake stalls and busy start:
   - Random gaps on s_valid/a_valid give results identical to scenario 2.
   - A start pulse while busy is ignored.
6. Reset mid-COMPUTE:
   - Assert rst after the 2nd a accept: busy=0, done=0, acc=0.
   - Next start with keep_secret=1 still enters LOAD_S.
